// File: rtl/renkon_linebuf_ctrl.sv
// renkon_linebuf_ctrl
//   Sequencer for the renkon line buffer. An accepted start request latches
//   the image/filter edges, fires a one-cycle buf_req and streams one input
//   memory read address per cycle in raster order. Each window reported by
//   the line buffer is tagged with its (row, col) position and counted. The
//   run ends when the line buffer raises buf_ack again.
//
// Ports
//   clk, xrst           clock, synchronous active-high reset
//   req                 start request (sampled only while idle)
//   img_size, fil_size  image / filter edge, latched on an accepted req
//   ack                 high when idle/ready, low while a run is in progress
//   buf_req             one-cycle start pulse to the line buffer
//   buf_ack, buf_valid  line buffer ready/done level, window valid strobe
//   mem_re, mem_addr    input-memory read enable / pixel index
//   blk_valid           tagged window valid (buf_valid delayed one cycle)
//   blk_row, blk_col    window position, 0..img-fil
//   blk_last            marks the final window of the run
//   blk_count           windows tagged in the current run
//   err                 sticky error; cleared by the next accepted req
module renkon_linebuf_ctrl #(
  parameter int IMAGE  = 32,
  parameter int FILTER = 3,
  parameter int AWIDTH = 10,
  parameter int LWIDTH = $clog2(IMAGE + 1)
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                req,
  input  logic [LWIDTH-1:0]   img_size,
  input  logic [LWIDTH-1:0]   fil_size,
  output logic                ack,
  output logic                buf_req,
  input  logic                buf_ack,
  input  logic                buf_valid,
  output logic                mem_re,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic                blk_valid,
  output logic [LWIDTH-1:0]   blk_row,
  output logic [LWIDTH-1:0]   blk_col,
  output logic                blk_last,
  output logic [2*LWIDTH-1:0] blk_count,
  output logic                err
);

  localparam int CW = 2 * LWIDTH;
  localparam int XW = AWIDTH + CW;
  localparam logic [LWIDTH-1:0] IMAGE_L  = LWIDTH'(IMAGE);
  localparam logic [LWIDTH-1:0] FILTER_L = LWIDTH'(FILTER);
  localparam logic [LWIDTH-1:0] ONE_L    = LWIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FEED, S_DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [LWIDTH-1:0]   span_reg, span_next;     // img - fil, last row/col index
  logic [CW-1:0]       npix_reg, npix_next;     // img*img
  logic [CW-1:0]       nwin_reg, nwin_next;     // (img-fil+1)**2
  logic [LWIDTH-1:0]   row_reg, row_next;       // position of the next window
  logic [LWIDTH-1:0]   col_reg, col_next;
  logic [1:0]          age_reg, age_next;       // cycles since buf_req, saturating at 2
  logic                ack_reg, ack_next;
  logic                buf_req_reg, buf_req_next;
  logic                mem_re_reg, mem_re_next;
  logic [AWIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic                blk_valid_reg, blk_valid_next;
  logic [LWIDTH-1:0]   blk_row_reg, blk_row_next;
  logic [LWIDTH-1:0]   blk_col_reg, blk_col_next;
  logic                blk_last_reg, blk_last_next;
  logic [CW-1:0]       blk_count_reg, blk_count_next;
  logic                err_reg, err_next;

  // Size legality and the run constants derived from the requested sizes.
  logic                size_ok;
  logic [LWIDTH-1:0]   span_in;
  logic [CW-1:0]       img_w, side_w;

  assign size_ok = (fil_size >= ONE_L) && (fil_size <= img_size) &&
                   (img_size <= IMAGE_L) && (fil_size <= FILTER_L);
  assign span_in = img_size - fil_size;
  assign img_w   = CW'(img_size);
  assign side_w  = CW'(span_in) + CW'(1);

  // A window is tagged only while a run is streaming, and only up to the
  // expected total; anything else is an error.
  logic                in_run, tag_fire, tag_ok;
  logic [CW-1:0]       count_after;
  logic [XW-1:0]       addr_ext, last_addr_ext;

  assign in_run        = (state_reg == S_FEED) || (state_reg == S_DRAIN);
  assign tag_fire      = buf_valid && in_run;
  assign tag_ok        = tag_fire && (blk_count_reg < nwin_reg);
  // Includes a window tagged on this same cycle so a final window arriving
  // together with buf_ack is not mistaken for a missing one.
  assign count_after   = blk_count_reg + CW'(tag_ok);
  assign addr_ext      = XW'(mem_addr_reg);
  assign last_addr_ext = XW'(npix_reg - CW'(1));

  always_comb begin
    state_next     = state_reg;
    span_next      = span_reg;
    npix_next      = npix_reg;
    nwin_next      = nwin_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    age_next       = age_reg;
    ack_next       = ack_reg;
    buf_req_next   = 1'b0;
    mem_re_next    = mem_re_reg;
    mem_addr_next  = mem_addr_reg;
    blk_valid_next = 1'b0;
    blk_row_next   = blk_row_reg;
    blk_col_next   = blk_col_reg;
    blk_last_next  = 1'b0;
    blk_count_next = blk_count_reg;
    err_next       = err_reg;

    unique case (state_reg)
      S_IDLE: begin
        ack_next    = 1'b1;
        mem_re_next = 1'b0;
        if (req) begin
          if (size_ok) begin
            span_next      = span_in;
            npix_next      = img_w * img_w;
            nwin_next      = side_w * side_w;
            row_next       = '0;
            col_next       = '0;
            age_next       = 2'd0;
            err_next       = 1'b0;
            blk_count_next = '0;
            // Outputs are registered, so the S_REQ outputs are loaded here.
            buf_req_next   = 1'b1;
            ack_next       = 1'b0;
            mem_re_next    = 1'b1;
            mem_addr_next  = '0;
            state_next     = S_REQ;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      S_REQ: begin
        age_next = 2'd1;
        // A 1x1 image has its only pixel read during S_REQ itself.
        if (npix_reg == CW'(1)) begin
          mem_re_next = 1'b0;
          state_next  = S_DRAIN;
        end else begin
          mem_addr_next = mem_addr_reg + AWIDTH'(1);
          state_next    = S_FEED;
        end
      end

      S_FEED: begin
        if (age_reg != 2'd2) age_next = age_reg + 2'd1;
        if (addr_ext == last_addr_ext) begin
          mem_re_next = 1'b0;
          state_next  = S_DRAIN;
        end else begin
          mem_addr_next = mem_addr_reg + AWIDTH'(1);
        end
      end

      S_DRAIN: begin
        if (age_reg != 2'd2) age_next = age_reg + 2'd1;
        // buf_ack is still the stale "ready" level right after buf_req, so
        // it is only trusted once the line buffer has had time to drop it.
        if (buf_ack && (age_reg == 2'd2)) begin
          ack_next   = 1'b1;
          state_next = S_IDLE;
          if (count_after != nwin_reg) err_next = 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    if (tag_fire) begin
      if (tag_ok) begin
        blk_valid_next = 1'b1;
        blk_row_next   = row_reg;
        blk_col_next   = col_reg;
        blk_last_next  = (row_reg == span_reg) && (col_reg == span_reg);
        blk_count_next = blk_count_reg + CW'(1);
        if (col_reg == span_reg) begin
          col_next = '0;
          row_next = row_reg + ONE_L;
        end else begin
          col_next = col_reg + ONE_L;
        end
      end else begin
        err_next = 1'b1;
      end
    end

    if (buf_valid && !in_run) err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_reg     <= S_IDLE;
      span_reg      <= '0;
      npix_reg      <= '0;
      nwin_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      age_reg       <= 2'd0;
      ack_reg       <= 1'b1;
      buf_req_reg   <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      blk_valid_reg <= 1'b0;
      blk_row_reg   <= '0;
      blk_col_reg   <= '0;
      blk_last_reg  <= 1'b0;
      blk_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      span_reg      <= span_next;
      npix_reg      <= npix_next;
      nwin_reg      <= nwin_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      age_reg       <= age_next;
      ack_reg       <= ack_next;
      buf_req_reg   <= buf_req_next;
      mem_re_reg    <= mem_re_next;
      mem_addr_reg  <= mem_addr_next;
      blk_valid_reg <= blk_valid_next;
      blk_row_reg   <= blk_row_next;
      blk_col_reg   <= blk_col_next;
      blk_last_reg  <= blk_last_next;
      blk_count_reg <= blk_count_next;
      err_reg       <= err_next;
    end
  end

  assign ack       = ack_reg;
  assign buf_req   = buf_req_reg;
  assign mem_re    = mem_re_reg;
  assign mem_addr  = mem_addr_reg;
  assign blk_valid = blk_valid_reg;
  assign blk_row   = blk_row_reg;
  assign blk_col   = blk_col_reg;
  assign blk_last  = blk_last_reg;
  assign blk_count = blk_count_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_renkon_linebuf_ctrl.sv
// Testbench for renkon_linebuf_ctrl. A behavioural line buffer (driven from
// a forked task) consumes the pixel stream and reports a window for every
// pixel that completes a fil x fil neighbourhood; expected tags and counts
// come from plain raster arithmetic over the requested sizes.
module tb_renkon_linebuf_ctrl;

  localparam int IMAGE  = 32;
  localparam int FILTER = 3;
  localparam int AWIDTH = 10;
  localparam int LWIDTH = 6;
  localparam int CW     = 2 * LWIDTH;

  logic              clk;
  logic              xrst;
  logic              req;
  logic [LWIDTH-1:0] img_size;
  logic [LWIDTH-1:0] fil_size;
  logic              ack;
  logic              buf_req;
  logic              buf_ack;
  logic              buf_valid;
  logic              mem_re;
  logic [AWIDTH-1:0] mem_addr;
  logic              blk_valid;
  logic [LWIDTH-1:0] blk_row;
  logic [LWIDTH-1:0] blk_col;
  logic              blk_last;
  logic [CW-1:0]     blk_count;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  // Line-buffer model controls.
  int m_img = 1;
  int m_fil = 1;
  bit m_drop_en = 0;
  int m_drop_idx = 0;
  bit m_spur = 0;

  renkon_linebuf_ctrl #(
    .IMAGE(IMAGE), .FILTER(FILTER), .AWIDTH(AWIDTH), .LWIDTH(LWIDTH)
  ) dut (
    .clk(clk), .xrst(xrst), .req(req), .img_size(img_size), .fil_size(fil_size),
    .ack(ack), .buf_req(buf_req), .buf_ack(buf_ack), .buf_valid(buf_valid),
    .mem_re(mem_re), .mem_addr(mem_addr), .blk_valid(blk_valid),
    .blk_row(blk_row), .blk_col(blk_col), .blk_last(blk_last),
    .blk_count(blk_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural line buffer: acts on the falling edge. A pixel that completes
  // a window produces buf_valid one cycle later; buf_ack rises once every
  // pixel has arrived and every window has been reported.
  task automatic linebuf_model();
    bit busy = 0;
    bit pend = 0;
    int seen = 0;
    int widx = 0;
    int r, c;
    bit win;
    forever begin
      @(negedge clk);
      if (xrst) begin
        busy = 0; pend = 0; seen = 0; widx = 0;
        buf_ack = 1'b1; buf_valid = 1'b0; m_spur = 0;
      end else begin
        buf_valid = pend | m_spur;
        m_spur = 0;
        pend = 0;
        if (buf_req) begin
          busy = 1; seen = 0; widx = 0; buf_ack = 1'b0;
        end
        if (busy && mem_re) begin
          r = int'(mem_addr) / m_img;
          c = int'(mem_addr) % m_img;
          win = (r >= m_fil - 1) && (c >= m_fil - 1);
          if (win) begin
            pend = !(m_drop_en && widx == m_drop_idx);
            widx++;
          end
          seen++;
        end
        if (busy && !buf_req && seen == m_img * m_img && !pend && !buf_valid) begin
          busy = 0;
          buf_ack = 1'b1;
        end
      end
    end
  endtask

  // One complete run with legal sizes; drop_idx >= 0 makes the line buffer
  // lose that window.
  task automatic run_check(input int img, input int fil, input int drop_idx);
    int n_pix = img * img;
    int w = img - fil + 1;
    int n_win = w * w;
    int exp_n = (drop_idx >= 0) ? n_win - 1 : n_win;
    int addr_q[$];
    int acyc_q[$];
    int row_q[$];
    int col_q[$];
    bit last_q[$];
    int req_pulses = 0;
    bit done = 0;
    logic [CW-1:0] fin_count = '0;
    logic fin_err = 1'b0;
    logic ack0;
    m_img = img; m_fil = fil;
    m_drop_en = (drop_idx >= 0); m_drop_idx = drop_idx;
    img_size = LWIDTH'(img); fil_size = LWIDTH'(fil); req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    ack0 = ack;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      if (buf_req) req_pulses++;
      if (mem_re) begin addr_q.push_back(int'(mem_addr)); acyc_q.push_back(cyc); end
      if (blk_valid) begin
        row_q.push_back(int'(blk_row)); col_q.push_back(int'(blk_col)); last_q.push_back(blk_last);
      end
      if (ack) begin
        done = 1; fin_count = blk_count; fin_err = err;
      end else begin
        @(posedge clk); #1;
      end
    end
    $display("run img=%0d fil=%0d drop=%0d: %0d reads, %0d windows, count=%0d err=%0b",
             img, fil, drop_idx, addr_q.size(), row_q.size(), fin_count, fin_err);
    n_checks++;
    if (ack0 !== 1'b0) begin n_fail++; $display("FAIL busy_ack: got %b want 0", ack0); end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL run_timeout: ack never returned (img=%0d fil=%0d)", img, fil); end
    n_checks++;
    if (req_pulses != 1) begin n_fail++; $display("FAIL buf_req_pulses: got %0d want 1", req_pulses); end
    n_checks++;
    if (addr_q.size() != n_pix) begin n_fail++; $display("FAIL read_count: got %0d want %0d", addr_q.size(), n_pix); end
    for (int i = 0; i < addr_q.size() && i < n_pix; i++) begin
      n_checks++;
      if (addr_q[i] != i || acyc_q[i] != i) begin
        n_fail++;
        $display("FAIL addr_seq[%0d]: got addr %0d at cycle %0d want addr %0d at cycle %0d",
                 i, addr_q[i], acyc_q[i], i, i);
        break;
      end
    end
    n_checks++;
    if (row_q.size() != exp_n) begin n_fail++; $display("FAIL window_count: got %0d want %0d", row_q.size(), exp_n); end
    for (int i = 0; i < row_q.size() && i < exp_n; i++) begin
      n_checks++;
      if (row_q[i] != i / w || col_q[i] != i % w || last_q[i] != (i == n_win - 1)) begin
        n_fail++;
        $display("FAIL window_tag[%0d]: got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)",
                 i, row_q[i], col_q[i], last_q[i], i / w, i % w, (i == n_win - 1));
        break;
      end
    end
    n_checks++;
    if (fin_count !== CW'(exp_n)) begin n_fail++; $display("FAIL blk_count: got %0d want %0d", fin_count, exp_n); end
    n_checks++;
    if (fin_err !== (drop_idx >= 0)) begin n_fail++; $display("FAIL run_err: got %b want %b", fin_err, (drop_idx >= 0)); end
    m_drop_en = 0;
  endtask

  task automatic check_reset_values(input string where);
    n_checks++;
    if ({ack, buf_req, mem_re, mem_addr, blk_valid, blk_row, blk_col, blk_last, blk_count, err} !==
        {1'b1, 1'b0, 1'b0, {AWIDTH{1'b0}}, 1'b0, {LWIDTH{1'b0}}, {LWIDTH{1'b0}}, 1'b0, {CW{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: ack=%b buf_req=%b mem_re=%b addr=%0d bv=%b row=%0d col=%0d last=%b cnt=%0d err=%b want idle/zero with ack=1",
               where, ack, buf_req, mem_re, mem_addr, blk_valid, blk_row, blk_col, blk_last, blk_count, err);
    end
    $display("reset check %s done", where);
  endtask

  task automatic test_reset();
    xrst = 1'b1; req = 1'b0; img_size = '0; fil_size = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    xrst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal(input int img, input int fil);
    int breq_seen = 0;
    int ack_low = 0;
    run_check(1, 1, -1);   // leaves err cleared before the illegal request
    img_size = LWIDTH'(img); fil_size = LWIDTH'(fil); req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (buf_req) breq_seen++;
      if (!ack) ack_low++;
      @(posedge clk); #1;
    end
    $display("illegal img=%0d fil=%0d: buf_req=%0d ack_low=%0d err=%b", img, fil, breq_seen, ack_low, err);
    n_checks++;
    if (breq_seen != 0) begin n_fail++; $display("FAIL illegal_buf_req: got %0d pulses want 0", breq_seen); end
    n_checks++;
    if (ack_low != 0) begin n_fail++; $display("FAIL illegal_ack: low for %0d cycles want 0", ack_low); end
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_run();
    bit hit = 0;
    m_img = 32; m_fil = 3; m_drop_en = 0;
    img_size = 6'd32; fil_size = 6'd3; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (mem_re && mem_addr == 10'd100) hit = 1;
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL mid_reset_reach: mem_addr 100 never seen, got %0d", mem_addr); end
    xrst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("mid_run_reset");
    xrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (buf_req !== 1'b0 || ack !== 1'b1) begin
        n_fail++; $display("FAIL post_reset_idle: buf_req=%b ack=%b want 0/1", buf_req, ack);
      end
    end
    run_check(4, 3, -1);
  endtask

  task automatic test_back_to_back();
    int rises = 0;
    int rise_cyc[2] = '{-1, -1};
    int breq_cyc[$];
    int tr[$];
    int tc[$];
    int cnt_rise1 = -1;
    int cnt_first2 = -1;
    logic prev_ack = 1'b1;
    m_img = 4; m_fil = 3; m_drop_en = 0;
    img_size = 6'd4; fil_size = 6'd3; req = 1'b1;
    for (int cyc = 0; cyc < 400 && rises < 2; cyc++) begin
      @(posedge clk); #1;
      if (buf_req) breq_cyc.push_back(cyc);
      if (blk_valid) begin
        tr.push_back(int'(blk_row)); tc.push_back(int'(blk_col));
        if (tr.size() == 5) cnt_first2 = int'(blk_count);
      end
      if (ack && !prev_ack) begin
        rise_cyc[rises] = cyc;
        if (rises == 0) cnt_rise1 = int'(blk_count);
        rises++;
        if (rises == 2) req = 1'b0;
      end
      prev_ack = ack;
    end
    req = 1'b0;
    $display("back_to_back: ack rises=%0d buf_req pulses=%0d windows=%0d", rises, breq_cyc.size(), tr.size());
    n_checks++;
    if (rises != 2) begin n_fail++; $display("FAIL b2b_runs: got %0d completions want 2", rises); end
    n_checks++;
    if (breq_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_buf_req: got %0d pulses want 2", breq_cyc.size()); end
    else begin
      n_checks++;
      if (breq_cyc[1] != rise_cyc[0] + 1) begin
        n_fail++; $display("FAIL b2b_restart: second buf_req at %0d want %0d", breq_cyc[1], rise_cyc[0] + 1);
      end
    end
    n_checks++;
    if (cnt_rise1 != 4) begin n_fail++; $display("FAIL b2b_count1: got %0d want 4", cnt_rise1); end
    n_checks++;
    if (cnt_first2 != 1) begin n_fail++; $display("FAIL b2b_count_restart: got %0d want 1", cnt_first2); end
    n_checks++;
    if (tr.size() != 8) begin n_fail++; $display("FAIL b2b_windows: got %0d want 8", tr.size()); end
    else begin
      for (int i = 4; i < 8; i++) begin
        n_checks++;
        if (tr[i] != (i - 4) / 2 || tc[i] != (i - 4) % 2) begin
          n_fail++; $display("FAIL b2b_tag[%0d]: got (%0d,%0d) want (%0d,%0d)", i, tr[i], tc[i], (i - 4) / 2, (i - 4) % 2);
        end
      end
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    run_check(4, 3, -1);
    m_spur = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("spurious buf_valid in idle: err=%b ack=%b", err, ack);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL spurious_err: got %b want 1", err); end
    n_checks++;
    if (blk_count !== CW'(4)) begin n_fail++; $display("FAIL spurious_count: got %0d want 4", blk_count); end
    run_check(4, 3, -1);   // an accepted req clears the sticky error
  endtask

  task automatic test_random();
    int img, fil;
    for (int k = 0; k < 4; k++) begin
      img = $urandom_range(IMAGE, 1);
      fil = $urandom_range((img < FILTER) ? img : FILTER, 1);
      run_check(img, fil, -1);
    end
  endtask

  initial begin
    xrst = 1'b1; req = 1'b0; img_size = '0; fil_size = '0;
    buf_ack = 1'b1; buf_valid = 1'b0;
    fork
      linebuf_model();
    join_none
    test_reset();
    run_check(32, 3, -1);
    run_check(4, 3, -1);
    run_check(1, 1, -1);
    run_check(3, 3, -1);
    test_illegal(4, 5);
    test_illegal(0, 1);
    test_illegal(4, 0);
    test_illegal(33, 3);
    test_reset_mid_run();
    test_back_to_back();
    run_check(32, 3, 450);
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
